// File: rtl/whack_round_ctrl_if.sv
// Signal bundle between the round controller, the button/LED front end and the
// interval timer. The controller is the master side; the environment is the slave.
interface whack_round_ctrl_if;
  logic       start;
  logic       hit_valid;
  logic [2:0] hit_idx;
  logic       timeout;
  logic       timer_rst_n;
  logic [2:0] interval;
  logic       dir;
  logic [7:0] mole;
  logic [7:0] score;
  logic [3:0] misses;
  logic [7:0] round;
  logic       game_over;
  logic       busy;

  modport master (
    input  start, hit_valid, hit_idx, timeout,
    output timer_rst_n, interval, dir, mole, score, misses, round, game_over, busy
  );

  modport slave (
    output start, hit_valid, hit_idx, timeout,
    input  timer_rst_n, interval, dir, mole, score, misses, round, game_over, busy
  );
endinterface

// File: rtl/whack_round_ctrl.sv
// Whack-a-mole round controller: re-arms the interval timer each round, lights a
// pseudo-random mole, and tracks score, misses, rounds and difficulty level.
module whack_round_ctrl #(
  parameter int ROUNDS         = 16,
  parameter int MAX_MISSES     = 3,
  parameter int LEVEL_HITS     = 4,
  parameter int START_INTERVAL = 7,
  parameter int MIN_INTERVAL   = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic            clk,
  input logic            rst_n,
  whack_round_ctrl_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] ACTIVE = 3'd2;
  localparam logic [2:0] RESULT = 3'd3;
  localparam logic [2:0] OVER   = 3'd4;

  logic [2:0] state;
  logic [7:0] lfsr;
  logic [2:0] mole_idx;
  logic [7:0] score_q;
  logic [3:0] misses_q;
  logic [7:0] round_q;

  logic [2:0] next_idx;
  logic       lfsr_fb;
  logic       is_hit;
  logic [8:0] round_inc;
  int         lvl;

  // Never light the same hole twice in a row.
  always_comb begin
    next_idx = lfsr[2:0];
    if (lfsr[2:0] == mole_idx)
      next_idx = lfsr[2:0] + 3'd1;
  end

  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign is_hit    = bus.hit_valid && (bus.hit_idx == mole_idx);
  assign round_inc = {1'b0, round_q} + 9'd1;

  // Signed int arithmetic so a large score cannot wrap the interval.
  always_comb begin
    lvl = START_INTERVAL - (int'(score_q) / LEVEL_HITS);
    if (lvl < MIN_INTERVAL)
      lvl = MIN_INTERVAL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      mole_idx <= 3'd0;
      score_q  <= 8'd0;
      misses_q <= 4'd0;
      round_q  <= 8'd0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            score_q  <= 8'd0;
            misses_q <= 4'd0;
            round_q  <= 8'd0;
            state    <= ARM;
          end
        end
        ARM: begin
          mole_idx <= next_idx;
          lfsr     <= {lfsr[6:0], lfsr_fb};
          state    <= ACTIVE;
        end
        ACTIVE: begin
          if (is_hit) begin
            if (score_q != 8'hFF)
              score_q <= score_q + 8'd1;
            state <= RESULT;
          end else if (bus.hit_valid || bus.timeout) begin
            misses_q <= misses_q + 4'd1;
            state    <= RESULT;
          end
        end
        RESULT: begin
          round_q <= round_inc[7:0];
          if ((round_inc == 9'(ROUNDS)) || (misses_q == 4'(MAX_MISSES)))
            state <= OVER;
          else
            state <= ARM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.timer_rst_n = (state == ACTIVE) || (state == RESULT);
  assign bus.interval    = 3'(lvl);
  assign bus.dir         = 1'b0;
  assign bus.mole        = (state == ACTIVE) ? (8'd1 << mole_idx) : 8'd0;
  assign bus.score       = score_q;
  assign bus.misses      = misses_q;
  assign bus.round       = round_q;
  assign bus.game_over   = (state == OVER);
  assign bus.busy        = (state == ARM) || (state == ACTIVE) || (state == RESULT);

endmodule
